// File: rtl/forwarding_unit.sv
// forwarding_unit: EX-stage bypass selects and MEM-to-MEM store forwarding with saturating event counters
module forwarding_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xm_regwrite,
    input  logic             mw_regwrite,
    input  logic             xm_memwrite,
    input  logic [REG_W-1:0] xm_rd,
    input  logic [REG_W-1:0] xm_rt,
    input  logic [REG_W-1:0] mw_rd,
    input  logic [REG_W-1:0] dx_rs,
    input  logic [REG_W-1:0] dx_rt,
    output logic [1:0]       forwarda,
    output logic [1:0]       forwardb,
    output logic             forwardmm,
    output logic [CNT_W-1:0] xx_count,
    output logic [CNT_W-1:0] mx_count,
    output logic [CNT_W-1:0] mm_count
);
    logic             xm_ok, mw_ok;
    logic [CNT_W-1:0] xx_d, mx_d, mm_d, xx_q, mx_q, mm_q;
    always_comb begin
        xm_ok     = xm_regwrite && xm_rd != '0;
        mw_ok     = mw_regwrite && mw_rd != '0;
        forwarda  = (xm_ok && xm_rd == dx_rs) ? 2'b01 : (mw_ok && mw_rd == dx_rs) ? 2'b10 : 2'b00;
        forwardb  = (xm_ok && xm_rd == dx_rt) ? 2'b01 : (mw_ok && mw_rd == dx_rt) ? 2'b10 : 2'b00;
        forwardmm = xm_memwrite && mw_ok && mw_rd == xm_rt;
        xx_d      = ((forwarda == 2'b01 || forwardb == 2'b01) && xx_q != '1) ? xx_q + 1'b1 : xx_q;
        mx_d      = ((forwarda == 2'b10 || forwardb == 2'b10) && mx_q != '1) ? mx_q + 1'b1 : mx_q;
        mm_d      = (forwardmm && mm_q != '1) ? mm_q + 1'b1 : mm_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            xx_q <= '0;
            mx_q <= '0;
            mm_q <= '0;
        end else begin
            xx_q <= xx_d;
            mx_q <= mx_d;
            mm_q <= mm_d;
        end
    end
    assign xx_count = xx_q;
    assign mx_count = mx_q;
    assign mm_count = mm_q;
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed vectors, expectations queued and checked by a negedge monitor
module tb_forwarding_unit;
    logic       clk = 1'b0;
    logic       rst, xm_regwrite, mw_regwrite, xm_memwrite;
    logic [3:0] xm_rd, xm_rt, mw_rd, dx_rs, dx_rt;
    logic [1:0] forwarda, forwardb, s_forwarda, s_forwardb;
    logic       forwardmm, s_forwardmm;
    logic [15:0] xx_count, mx_count, mm_count;
    logic [1:0]  s_xx, s_mx, s_mm;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] fa, fb;
        logic       fmm;
        int         xx, mx, mm;
    } exp_t;
    exp_t q[$];

    forwarding_unit dut (
        .clk(clk), .rst(rst), .xm_regwrite(xm_regwrite), .mw_regwrite(mw_regwrite),
        .xm_memwrite(xm_memwrite), .xm_rd(xm_rd), .xm_rt(xm_rt), .mw_rd(mw_rd),
        .dx_rs(dx_rs), .dx_rt(dx_rt), .forwarda(forwarda), .forwardb(forwardb),
        .forwardmm(forwardmm), .xx_count(xx_count), .mx_count(mx_count), .mm_count(mm_count)
    );

    forwarding_unit #(.REG_W(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .xm_regwrite(xm_regwrite), .mw_regwrite(mw_regwrite),
        .xm_memwrite(xm_memwrite), .xm_rd(xm_rd), .xm_rt(xm_rt), .mw_rd(mw_rd),
        .dx_rs(dx_rs), .dx_rt(dx_rt), .forwarda(s_forwarda), .forwardb(s_forwardb),
        .forwardmm(s_forwardmm), .xx_count(s_xx), .mx_count(s_mx), .mm_count(s_mm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("forwarda", int'(forwarda), int'(e.fa));
            chk("forwardb", int'(forwardb), int'(e.fb));
            chk("forwardmm", int'(forwardmm), int'(e.fmm));
            chk("xx_count", int'(xx_count), e.xx);
            chk("mx_count", int'(mx_count), e.mx);
            chk("mm_count", int'(mm_count), e.mm);
            chk("s_forwarda", int'(s_forwarda), int'(e.fa));
            chk("s_xx_count", int'(s_xx), sat3(e.xx));
            chk("s_mx_count", int'(s_mx), sat3(e.mx));
            chk("s_mm_count", int'(s_mm), sat3(e.mm));
        end
    end

    task automatic drive(input logic r, xr, mr, xw, input logic [3:0] xrd, xrt, mrd, rs, rt,
                         input logic [1:0] fa, fb, input logic fmm, input int xx, mx, mm);
        exp_t e;
        rst = r; xm_regwrite = xr; mw_regwrite = mr; xm_memwrite = xw;
        xm_rd = xrd; xm_rt = xrt; mw_rd = mrd; dx_rs = rs; dx_rt = rt;
        e.fa = fa; e.fb = fb; e.fmm = fmm; e.xx = xx; e.mx = mx; e.mm = mm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; xm_regwrite = 0; mw_regwrite = 0; xm_memwrite = 0;
        xm_rd = 0; xm_rt = 0; mw_rd = 0; dx_rs = 0; dx_rt = 0;
        @(posedge clk);
        #1;
        //    rst xr mr xw xrd xrt mrd rs rt   fa     fb     fmm  xx mx mm
        drive(0, 1, 1, 1, 1, 1, 2, 1, 2, 2'b01, 2'b10, 1'b0, 0, 0, 0);
        drive(0, 1, 1, 1, 1, 1, 2, 1, 2, 2'b01, 2'b10, 1'b0, 1, 1, 0);
        drive(0, 1, 1, 1, 1, 1, 2, 1, 2, 2'b01, 2'b10, 1'b0, 2, 2, 0);
        drive(0, 1, 1, 1, 1, 1, 2, 1, 2, 2'b01, 2'b10, 1'b0, 3, 3, 0);
        drive(0, 1, 1, 1, 2, 1, 1, 1, 2, 2'b10, 2'b01, 1'b1, 4, 4, 0);
        drive(0, 0, 1, 1, 2, 1, 1, 3, 2, 2'b00, 2'b00, 1'b1, 5, 5, 1);
        drive(0, 0, 1, 1, 2, 1, 2, 2, 2, 2'b10, 2'b10, 1'b0, 5, 5, 2);
        drive(0, 1, 1, 1, 2, 1, 2, 2, 2, 2'b01, 2'b01, 1'b0, 5, 6, 2);
        drive(1, 1, 1, 1, 2, 1, 2, 2, 2, 2'b01, 2'b01, 1'b0, 6, 6, 2);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        drive(0, 1, 0, 1, 5, 6, 6, 5, 6, 2'b01, 2'b00, 1'b0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 1, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations unchecked, 0 required", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
